hdmi_i2c: RTL and testbench

HDMI_I2C -- requirements
Module: hdmi_i2c

---
 rtl/hdmi_i2c.sv | 262 ++++++++++++++++++++++++++
 tb/tb_hdmi_i2c.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_i2c.sv
// rtl/hdmi_i2c.sv - I2C master for single-register access to an HDMI transmitter
//
// Ports:
//   clk, rstn          system clock, asynchronous active-low reset
//   hdreq, hdwr        request strobe (held until hdack), 1 = write / 0 = read
//   hdaddr, hdwrdata   register address and write data
//   hdlast             1 = end with STOP, 0 = keep the bus (SCL held low)
//   hdrddata           read data, updated only on a successful read
//   hdack, hderr       one-cycle completion pulse, error pulse coincident with hdack
//   scl_oe, scl_i      SCL open-drain pull-down enable / sampled line level
//   sda_oe, sda_i      SDA open-drain pull-down enable / sampled line level
module hdmi_i2c #(
    parameter logic [6:0]  DEVADDR = 7'h39,
    parameter int unsigned CLKDIV  = 250
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       hdreq,
    input  logic       hdwr,
    input  logic [7:0] hdaddr,
    input  logic [7:0] hdwrdata,
    input  logic       hdlast,
    output logic [7:0] hdrddata,
    output logic       hdack,
    output logic       hderr,
    output logic       scl_oe,
    input  logic       scl_i,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam logic [15:0] DIV_MAX = 16'(CLKDIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RSTART,
        ST_SHIFT,
        ST_ACKBIT,
        ST_STOP,
        ST_HOLD
    } state_t;

    state_t      state, state_d;
    logic [1:0]  phase, phase_d;
    logic [2:0]  bitcnt, bitcnt_d;
    logic [1:0]  bytecnt, bytecnt_d;
    logic        err_q, err_d;
    logic        nack_q;
    logic [7:0]  rx_sh;
    logic        rd_q, last_q;
    logic [7:0]  addr_q, wdata_q;
    logic        accept, done;
    logic        scl_oe_d, sda_oe_d;

    logic        scl_meta, scl_s, sda_meta, sda_s;
    logic [15:0] div_cnt;
    logic        busy, stretch, tick;
    logic [7:0]  tx_byte;
    logic        rx_byte;

    // Line synchronizers; idle bus level is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_meta <= 1'b1;
            scl_s    <= 1'b1;
            sda_meta <= 1'b1;
            sda_s    <= 1'b1;
        end else begin
            scl_meta <= scl_i;
            scl_s    <= scl_meta;
            sda_meta <= sda_i;
            sda_s    <= sda_meta;
        end
    end

    // Quarter-period divider. Parked at zero when no bus activity is in
    // progress, frozen while a slave holds a released SCL low.
    assign busy    = (state != ST_IDLE) && (state != ST_HOLD);
    assign stretch = !scl_oe && !scl_s;
    assign tick    = busy && !stretch && (div_cnt == DIV_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= 16'd0;
        end else if (!busy) begin
            div_cnt <= 16'd0;
        end else if (!stretch) begin
            div_cnt <= (div_cnt == DIV_MAX) ? 16'd0 : div_cnt + 16'd1;
        end
    end

    // Byte 2 is the write data on a write, the read-address byte on a read;
    // byte 3 only exists on a read and is received.
    always_comb begin
        tx_byte = 8'h00;
        case (bytecnt)
            2'd0:    tx_byte = {DEVADDR, 1'b0};
            2'd1:    tx_byte = addr_q;
            2'd2:    tx_byte = rd_q ? {DEVADDR, 1'b1} : wdata_q;
            default: tx_byte = 8'h00;
        endcase
    end

    assign rx_byte = rd_q && (bytecnt == 2'd3);

    // Next-state logic. Every bus state spans four ticks (phase 0..3).
    always_comb begin
        state_d   = state;
        phase_d   = phase;
        bitcnt_d  = bitcnt;
        bytecnt_d = bytecnt;
        err_d     = err_q;
        accept    = 1'b0;
        done      = 1'b0;

        if (tick) begin
            phase_d = phase + 2'd1;
        end

        case (state)
            ST_IDLE, ST_HOLD: begin
                // The hdack cycle itself is ignored so a held hdreq is not
                // mistaken for a new request before the requester sees hdack.
                if (hdreq && !hdack) begin
                    accept    = 1'b1;
                    state_d   = (state == ST_HOLD) ? ST_RSTART : ST_START;
                    phase_d   = 2'd0;
                    bytecnt_d = 2'd0;
                    err_d     = 1'b0;
                end
            end
            ST_START, ST_RSTART: begin
                if (tick && phase == 2'd3) begin
                    state_d  = ST_SHIFT;
                    bitcnt_d = 3'd7;
                end
            end
            ST_SHIFT: begin
                if (tick && phase == 2'd3) begin
                    if (bitcnt == 3'd0) begin
                        state_d = ST_ACKBIT;
                    end else begin
                        bitcnt_d = bitcnt - 3'd1;
                    end
                end
            end
            ST_ACKBIT: begin
                if (tick && phase == 2'd3) begin
                    if (nack_q && !rx_byte) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else if (bytecnt == 2'd3 || (!rd_q && bytecnt == 2'd2)) begin
                        state_d = last_q ? ST_STOP : ST_HOLD;
                        done    = !last_q;
                    end else if (rd_q && bytecnt == 2'd1) begin
                        state_d   = ST_RSTART;
                        bytecnt_d = 2'd2;
                    end else begin
                        state_d   = ST_SHIFT;
                        bitcnt_d  = 3'd7;
                        bytecnt_d = bytecnt + 2'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick && phase == 2'd3) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin decode. SCL is low in phases 0 and 3 of a bit; SDA only moves in
    // phase 0 except for the START/STOP edges in phase 1/2 with SCL high.
    always_comb begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        case (state)
            ST_START: begin
                scl_oe_d = (phase == 2'd3);
                sda_oe_d = (phase != 2'd0);
            end
            ST_RSTART: begin
                scl_oe_d = (phase == 2'd0) || (phase == 2'd3);
                sda_oe_d = phase[1];
            end
            ST_SHIFT: begin
                scl_oe_d = (phase == 2'd0) || (phase == 2'd3);
                sda_oe_d = !rx_byte && !tx_byte[bitcnt];
            end
            ST_ACKBIT: begin
                // Released: slave drives its ACK, or the master NACKs a read.
                scl_oe_d = (phase == 2'd0) || (phase == 2'd3);
                sda_oe_d = 1'b0;
            end
            ST_STOP: begin
                scl_oe_d = (phase == 2'd0);
                sda_oe_d = !phase[1];
            end
            ST_HOLD: begin
                scl_oe_d = 1'b1;
                sda_oe_d = 1'b0;
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            phase    <= 2'd0;
            bitcnt   <= 3'd0;
            bytecnt  <= 2'd0;
            err_q    <= 1'b0;
            nack_q   <= 1'b0;
            rx_sh    <= 8'h00;
            rd_q     <= 1'b0;
            last_q   <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            hdack    <= 1'b0;
            hderr    <= 1'b0;
            hdrddata <= 8'h00;
        end else begin
            state   <= state_d;
            phase   <= phase_d;
            bitcnt  <= bitcnt_d;
            bytecnt <= bytecnt_d;
            err_q   <= err_d;
            scl_oe  <= scl_oe_d;
            sda_oe  <= sda_oe_d;
            hdack   <= done;
            hderr   <= done && err_d;
            if (accept) begin
                rd_q    <= !hdwr;
                last_q  <= hdlast;
                addr_q  <= hdaddr;
                wdata_q <= hdwrdata;
            end
            if (tick && phase == 2'd2 && state == ST_ACKBIT) begin
                nack_q <= sda_s;
            end
            if (tick && phase == 2'd2 && state == ST_SHIFT) begin
                rx_sh <= {rx_sh[6:0], sda_s};
            end
            if (done && !err_d && rd_q) begin
                hdrddata <= rx_sh;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_i2c.sv
// tb/tb_hdmi_i2c.sv - directed bench for hdmi_i2c with a behavioural I2C slave
module tb_hdmi_i2c;

    localparam int CLKDIV  = 4;
    localparam int TMO     = 4000;
    localparam int EV_STA  = 256;
    localparam int EV_STO  = 512;

    logic       clk = 1'b0;
    logic       rstn;
    logic       hdreq, hdwr, hdlast;
    logic [7:0] hdaddr, hdwrdata;
    logic [7:0] hdrddata;
    logic       hdack, hderr;
    logic       scl_oe, sda_oe;

    logic       sl_scl = 1'b0;
    logic       sl_sda = 1'b0;
    wire        scl_bus = !(scl_oe || sl_scl);
    wire        sda_bus = !(sda_oe || sl_sda);

    int         ncmp = 0;
    int         nbad = 0;
    int         ack_cnt = 0;

    // slave model configuration (written by the stimulus only)
    logic [7:0] rd_byte = 8'h40;
    bit         nack_addr = 0;
    bit         stretch_en = 0;

    // slave model observations (written by the slave only)
    int         log_q[$];
    int         stop_pulses = 0;
    bit         last_ack = 0;

    int         exp_q[$];
    int         base;

    hdmi_i2c #(.DEVADDR(7'h39), .CLKDIV(CLKDIV)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .hdreq    (hdreq),
        .hdwr     (hdwr),
        .hdaddr   (hdaddr),
        .hdwrdata (hdwrdata),
        .hdlast   (hdlast),
        .hdrddata (hdrddata),
        .hdack    (hdack),
        .hderr    (hderr),
        .scl_oe   (scl_oe),
        .scl_i    (scl_bus),
        .sda_oe   (sda_oe),
        .sda_i    (sda_bus)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (hdack) ack_cnt++;
        end
    end

    // Behavioural slave: logs START/STOP and every byte seen on the bus,
    // ACKs (or NACKs) received bytes, transmits rd_byte after a read address.
    initial begin : slave
        bit         p_scl, p_sda, tx_mode, addr_read;
        int         bitpos, frame_byte, pulses, stretch_left;
        logic [7:0] sh;
        p_scl = 1; p_sda = 1; tx_mode = 0; addr_read = 0;
        bitpos = 0; frame_byte = 0; pulses = 0; stretch_left = 0; sh = 8'h00;
        forever begin
            @(negedge clk);
            if (stretch_left > 0) begin
                stretch_left--;
                if (stretch_left == 0) sl_scl = 1'b0;
            end
            if (p_scl && scl_bus && p_sda && !sda_bus) begin
                log_q.push_back(EV_STA);
                bitpos = 0; frame_byte = 0; tx_mode = 0; sl_sda = 1'b0; pulses = 0;
            end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
                log_q.push_back(EV_STO);
                stop_pulses = pulses;
                tx_mode = 0; sl_sda = 1'b0;
            end else if (!p_scl && scl_bus) begin
                if (bitpos < 8) sh = {sh[6:0], sda_bus};
                else last_ack = sda_bus;
                bitpos++;
            end else if (p_scl && !scl_bus) begin
                if (bitpos != 0) pulses++;
                if (bitpos == 8) begin
                    log_q.push_back(int'(sh));
                    if (tx_mode) begin
                        sl_sda = 1'b0;
                    end else begin
                        sl_sda = !(nack_addr && frame_byte == 0);
                        if (frame_byte == 0) addr_read = sh[0];
                    end
                end else if (bitpos == 9) begin
                    bitpos = 0;
                    if (tx_mode) begin
                        tx_mode = 0; sl_sda = 1'b0;
                    end else if (frame_byte == 0 && addr_read && sl_sda) begin
                        tx_mode = 1; sl_sda = !rd_byte[7];
                    end else begin
                        sl_sda = 1'b0;
                    end
                    frame_byte++;
                end else if (tx_mode && bitpos > 0) begin
                    sl_sda = !rd_byte[7 - bitpos];
                end
                // Hold covers the master's own two low quarters plus the stretch.
                if (stretch_en && frame_byte == 1 && bitpos == 3) begin
                    sl_scl = 1'b1;
                    stretch_left = 2 * CLKDIV + 505;
                end
            end
            p_scl = scl_bus; p_sda = sda_bus;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag);
        int n;
        n = log_q.size() - base;
        check($sformatf("%s_len", tag), n, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_ev%0d", tag, i),
                  (base + i < log_q.size()) ? log_q[base + i] : -1, exp_q[i]);
        end
    endtask

    task automatic do_req(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic last, output logic err, output logic [7:0] rdv,
                          output int cyc);
        hdwr = wr; hdaddr = a; hdwrdata = d; hdlast = last; hdreq = 1'b1;
        cyc = 0; err = 1'b0; rdv = 8'h00;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            cyc++;
            if (hdack) begin
                err = hderr;
                rdv = hdrddata;
                break;
            end
        end
        if (cyc >= TMO) check("req_timeout", hdack, 1);
        hdreq = 1'b0;
    endtask

    initial begin : stim
        logic       err;
        logic [7:0] rdv;
        int         cyc, base_cyc, acks0;

        rstn = 1'b0; hdreq = 1'b0; hdwr = 1'b0; hdlast = 1'b0;
        hdaddr = 8'h00; hdwrdata = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_hdack", hdack, 0);
        check("rst_hderr", hderr, 0);
        check("rst_rddata", hdrddata, 8'h00);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // write 0x41 <= 0x10, STOP
        base = log_q.size(); acks0 = ack_cnt;
        do_req(1'b1, 8'h41, 8'h10, 1'b1, err, rdv, cyc);
        base_cyc = cyc;
        repeat (20) @(negedge clk);
        check("wr_err", err, 0);
        exp_q = {EV_STA, 'h72, 'h41, 'h10, EV_STO};
        check_log("wr");
        check("wr_acks", ack_cnt - acks0, 1);
        check("wr_pulses", stop_pulses, 27);

        // read 0x42, slave returns 0x40
        base = log_q.size(); acks0 = ack_cnt;
        do_req(1'b0, 8'h42, 8'h00, 1'b1, err, rdv, cyc);
        repeat (20) @(negedge clk);
        check("rd_err", err, 0);
        check("rd_data", rdv, 8'h40);
        exp_q = {EV_STA, 'h72, 'h42, EV_STA, 'h73, 'h40, EV_STO};
        check_log("rd");
        check("rd_master_nack", last_ack, 1);
        check("rd_acks", ack_cnt - acks0, 1);

        // slave NACKs the device address
        nack_addr = 1;
        base = log_q.size(); acks0 = ack_cnt;
        do_req(1'b1, 8'h05, 8'h55, 1'b1, err, rdv, cyc);
        repeat (20) @(negedge clk);
        nack_addr = 0;
        check("nack_err", err, 1);
        check("nack_rddata", rdv, 8'h40);
        exp_q = {EV_STA, 'h72, EV_STO};
        check_log("nack");
        check("nack_pulses", stop_pulses, 9);
        check("nack_acks", ack_cnt - acks0, 1);

        // clock stretching in byte 2
        stretch_en = 1;
        base = log_q.size();
        do_req(1'b1, 8'h41, 8'h10, 1'b1, err, rdv, cyc);
        repeat (20) @(negedge clk);
        stretch_en = 0;
        check("str_err", err, 0);
        exp_q = {EV_STA, 'h72, 'h41, 'h10, EV_STO};
        check_log("str");
        check("str_delay", cyc >= base_cyc + 500, 1);

        // reset during the data byte of a write
        base = log_q.size(); acks0 = ack_cnt;
        hdwr = 1'b1; hdaddr = 8'h41; hdwrdata = 8'h10; hdlast = 1'b1; hdreq = 1'b1;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            if (log_q.size() >= base + 3) break;
        end
        repeat (4 * CLKDIV) @(negedge clk);
        for (int k = 0; k < 100; k++) begin
            if (scl_oe) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("mid_rst_scl_oe", scl_oe, 0);
        check("mid_rst_sda_oe", sda_oe, 0);
        hdreq = 1'b0;
        repeat (10) @(negedge clk);
        rstn = 1'b1;
        repeat (50) @(negedge clk);
        check("mid_rst_noack", ack_cnt - acks0, 0);
        base = log_q.size(); acks0 = ack_cnt;
        do_req(1'b1, 8'h41, 8'h10, 1'b1, err, rdv, cyc);
        repeat (20) @(negedge clk);
        check("post_rst_err", err, 0);
        exp_q = {EV_STA, 'h72, 'h41, 'h10, EV_STO};
        check_log("post_rst");
        check("post_rst_acks", ack_cnt - acks0, 1);

        // two writes, first keeps the bus; hdreq stays high across hdack
        base = log_q.size(); acks0 = ack_cnt;
        do_req(1'b1, 8'h10, 8'hA5, 1'b0, err, rdv, cyc);
        check("hold1_err", err, 0);
        do_req(1'b1, 8'h11, 8'h5A, 1'b1, err, rdv, cyc);
        repeat (20) @(negedge clk);
        check("hold2_err", err, 0);
        exp_q = {EV_STA, 'h72, 'h10, 'hA5, EV_STA, 'h72, 'h11, 'h5A, EV_STO};
        check_log("hold");
        check("hold_acks", ack_cnt - acks0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
